imem_loader: RTL

Instruction-memory responder and boot loader for the single-cycle MIPS core. It serves the core's instruction fetch port (pc in, instr out) from an internal word-addressed RAM. The RAM is filled from a byte stream over a valid/ready handshake, and the core is held in reset until a complete, length-checked image has been written. It sits between the core's fetch interface and an external host/UART byte source.

---
 rtl/imem_loader.sv | 121 ++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - instruction RAM responder with length-checked byte-stream boot loader
module imem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_load_start,
    input  logic                  i_byte_valid,
    input  logic [7:0]            i_byte_data,
    output logic                  o_byte_ready,
    input  logic [DATA_WIDTH-1:0] i_pc,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic                  o_core_reset_n,
    output logic                  o_load_done,
    output logic                  o_load_error,
    output logic [15:0]           o_word_count
);
    localparam int          DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [16:0] MAX_WORDS = 17'(DEPTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic [2:0]            r_state;
    logic                  r_len_hi;
    logic [7:0]            r_len_lo;
    logic [1:0]            r_byte_idx;
    logic [ADDR_WIDTH:0]   r_word_idx;
    logic [DATA_WIDTH-9:0] r_held;
    logic [15:0]           r_word_count;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_word_done;
    logic                  w_last_word;
    logic                  w_len_bad;
    logic [15:0]           w_len;
    logic [ADDR_WIDTH:0]   w_word_idx_next;
    logic                  w_pc_in_range;
    logic                  w_unused_pc_lo;

    assign o_byte_ready    = (r_state == S_LEN) || (r_state == S_LOAD);
    assign o_core_reset_n  = (r_state == S_RUN);
    assign o_load_done     = (r_state == S_RUN);
    assign o_load_error    = (r_state == S_ERR);
    assign o_word_count    = r_word_count;

    assign w_accept        = i_byte_valid && o_byte_ready;
    assign w_len           = {i_byte_data, r_len_lo};
    assign w_len_bad       = (w_len == 16'd0) || ({1'b0, w_len} > MAX_WORDS);
    assign w_word_done     = w_accept && (r_state == S_LOAD) && (r_byte_idx == 2'd3);
    assign w_word_idx_next = r_word_idx + {{ADDR_WIDTH{1'b0}}, 1'b1};
    // word_idx is one bit wider than the RAM index so a full-depth image terminates
    assign w_last_word     = (16'(w_word_idx_next) == r_word_count);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_len_hi     <= 1'b0;
            r_len_lo     <= 8'd0;
            r_byte_idx   <= 2'd0;
            r_word_idx   <= '0;
            r_held       <= '0;
            r_word_count <= 16'd0;
        end else begin
            case (r_state)
                S_LEN: begin
                    if (w_accept) begin
                        if (!r_len_hi) begin
                            r_len_lo <= i_byte_data;
                            r_len_hi <= 1'b1;
                        end else begin
                            r_word_count <= w_len;
                            r_len_hi     <= 1'b0;
                            r_byte_idx   <= 2'd0;
                            r_word_idx   <= '0;
                            r_state      <= w_len_bad ? S_ERR : S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0: r_held[7:0]   <= i_byte_data;
                            2'd1: r_held[15:8]  <= i_byte_data;
                            2'd2: r_held[23:16] <= i_byte_data;
                            default: begin
                                r_word_idx <= w_word_idx_next;
                                if (w_last_word) begin
                                    r_state <= S_RUN;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    if (i_load_start) begin
                        r_state  <= S_LEN;
                        r_len_hi <= 1'b0;
                    end
                end
            endcase
        end
    end

    // RAM has no reset so earlier images survive reset and shorter reloads
    always_ff @(posedge i_clk) begin
        if (w_word_done && !i_reset) begin
            r_mem[r_word_idx[ADDR_WIDTH-1:0]] <= {i_byte_data, r_held};
        end
    end

    assign w_pc_in_range  = (i_pc[DATA_WIDTH-1:ADDR_WIDTH+2] == '0);
    assign w_unused_pc_lo = ^i_pc[1:0];
    assign o_instr = ((r_state == S_RUN) && w_pc_in_range) ? r_mem[i_pc[ADDR_WIDTH+1:2]] : '0;
endmodule
